// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU: op codes, FSM state encoding and the signed
// overflow helper used by the add/sub path.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_SLT = 4'b0001;
  localparam logic [3:0] OP_OR  = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_SUB = 4'b1100;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StMul,
    StDone
  } state_e;

  // Carry into the MSB is recovered as a ^ b ^ sum at that bit; overflow is it XOR carry out.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic sum_msb, input logic carry_out);
    return (a_msb ^ b_msb ^ sum_msb) ^ carry_out;
  endfunction

endpackage

// File: rtl/alu_logic.sv
// Combinational single-cycle ALU ops and flags.
// FAST_SHIFT_EN: when defined, SLL/SRA use a barrel shifter here; otherwise shifts return A
// (the zero-distance result) and the iterative path in the top handles non-zero distances.
module alu_logic
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic [3:0]         op_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  output logic [WIDTH-1:0]   result_o,
  output logic               zero_o,
  output logic               overflow_o,
  output logic               carry_out_o
);

  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             legal;

  assign is_sub         = (op_i == OP_SUB);
  assign b_eff          = is_sub ? ~b_i : b_i;
  assign {cout, sum}    = {1'b0, a_i} + {1'b0, b_eff} + (WIDTH + 1)'(is_sub);

`ifndef FAST_SHIFT_EN
  logic unused_shamt;
  assign unused_shamt = ^shamt_i;
`endif

  // Decode op into result and add/sub flags; unknown codes give all zeros
  always_comb begin
    result_o    = '0;
    overflow_o  = 1'b0;
    carry_out_o = 1'b0;
    legal       = 1'b1;
    case (op_i)
      OP_AND: result_o = a_i & b_i;
      OP_OR:  result_o = a_i | b_i;
      OP_XOR: result_o = a_i ^ b_i;
      OP_ADD, OP_SUB: begin
        result_o    = sum;
        carry_out_o = cout;
        overflow_o  = signed_ovf(a_i[WIDTH-1], b_eff[WIDTH-1], sum[WIDTH-1], cout);
      end
      OP_SLT: result_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
`ifdef FAST_SHIFT_EN
      OP_SLL: result_o = a_i << shamt_i;
      OP_SRA: result_o = $signed(a_i) >>> shamt_i;
`else
      OP_SLL, OP_SRA: result_o = a_i;
`endif
      // MUL never takes this path; it is handled iteratively in the top.
      default: legal = 1'b0;
    endcase
    zero_o = legal && (result_o == '0);
  end

endmodule

// File: rtl/iter_alu.sv
// Handshaked ALU: logic/add-class ops in one cycle, iterative shifts (1 bit/cycle) and
// shift-add multiply (1 multiplier bit/cycle). Result and flags held in DONE until taken.
// FAST_SHIFT_EN: when defined, shifts complete in one cycle via the barrel shifter.
module iter_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               InValid,
  output logic               InReady,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [3:0]         Op,
  input  logic [SHAMT_W-1:0] Shamt,
  output logic               OutValid,
  input  logic               OutReady,
  output logic [WIDTH-1:0]   Result,
  output logic               Zero,
  output logic               Overflow,
  output logic               CarryOut,
  output logic               Busy
);

  localparam int unsigned CNT_W = SHAMT_W + 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;       // shift accumulator / multiplicand
  logic [WIDTH-1:0] b_q, b_d;       // multiplier, consumed LSB first
  logic [WIDTH-1:0] prod_q, prod_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sra_q, sra_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             cout_q, cout_d;

  logic [WIDTH-1:0] lg_result;
  logic             lg_zero, lg_ovf, lg_cout;
  logic [WIDTH-1:0] shift_nxt;
  logic [WIDTH-1:0] prod_nxt;

  alu_logic #(
    .WIDTH (WIDTH)
  ) u_alu_logic (
    .a_i         (A),
    .b_i         (B),
    .op_i        (Op),
    .shamt_i     (Shamt),
    .result_o    (lg_result),
    .zero_o      (lg_zero),
    .overflow_o  (lg_ovf),
    .carry_out_o (lg_cout)
  );

  assign shift_nxt = sra_q ? {a_q[WIDTH-1], a_q[WIDTH-1:1]} : {a_q[WIDTH-2:0], 1'b0};
  assign prod_nxt  = prod_q + (b_q[0] ? a_q : '0);

  assign InReady  = (state_q == StIdle);
  assign OutValid = (state_q == StDone);
  assign Busy     = (state_q != StIdle);
  assign Result   = result_q;
  assign Zero     = zero_q;
  assign Overflow = ovf_q;
  assign CarryOut = cout_q;

  // Next-state: accept in IDLE, iterate in SHIFT/MUL, hold result in DONE until taken
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    sra_d    = sra_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    cout_d   = cout_q;
    unique case (state_q)
      StIdle: begin
        if (InValid) begin
          a_d    = A;
          b_d    = B;
          sra_d  = (Op == OP_SRA);
          prod_d = '0;
          if (Op == OP_MUL) begin
            cnt_d   = CNT_W'(WIDTH);
            state_d = StMul;
`ifndef FAST_SHIFT_EN
          end else if (((Op == OP_SLL) || (Op == OP_SRA)) && (Shamt != '0)) begin
            cnt_d   = CNT_W'(Shamt);
            state_d = StShift;
`endif
          end else begin
            result_d = lg_result;
            zero_d   = lg_zero;
            ovf_d    = lg_ovf;
            cout_d   = lg_cout;
            state_d  = StDone;
          end
        end
      end
      StShift: begin
        a_d   = shift_nxt;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          result_d = shift_nxt;
          zero_d   = (shift_nxt == '0);
          ovf_d    = 1'b0;
          cout_d   = 1'b0;
          state_d  = StDone;
        end
      end
      StMul: begin
        prod_d = prod_nxt;
        a_d    = a_q << 1;
        b_d    = b_q >> 1;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          result_d = prod_nxt;
          zero_d   = (prod_nxt == '0);
          ovf_d    = 1'b0;
          cout_d   = 1'b0;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (OutReady) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      sra_q    <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      sra_q    <= sra_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      cout_q   <= cout_d;
    end
  end

endmodule

// File: tb/tb_iter_alu.sv
// Directed bench for iter_alu at WIDTH=16 and WIDTH=32 with hand-computed expectations.
module tb_iter_alu;

  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_SLT = 4'b0001;
  localparam logic [3:0] C_OR  = 4'b0010;
  localparam logic [3:0] C_XOR = 4'b0011;
  localparam logic [3:0] C_ADD = 4'b0100;
  localparam logic [3:0] C_SLL = 4'b0110;
  localparam logic [3:0] C_SRA = 4'b0111;
  localparam logic [3:0] C_MUL = 4'b1000;
  localparam logic [3:0] C_SUB = 4'b1100;
  localparam logic [3:0] C_BAD = 4'b1111;

`ifdef FAST_SHIFT_EN
  localparam int SRA3_LAT  = 1;
  localparam int SLL4_LAT  = 1;
  localparam int SLL31_LAT = 1;
`else
  localparam int SRA3_LAT  = 4;
  localparam int SLL4_LAT  = 5;
  localparam int SLL31_LAT = 32;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, zero, ovf, cout, busy;
  logic [15:0] a, b, result;
  logic [3:0]  op, shamt;
  logic        in_valid32, in_ready32, out_valid32, out_ready32, zero32, ovf32, cout32, busy32;
  logic [31:0] a32, b32, result32;
  logic [3:0]  op32;
  logic [4:0]  shamt32;

  int total = 0;
  int bad   = 0;
  int lat;
  int nres;

  always #5 clk = ~clk;

  iter_alu #(.WIDTH(16)) u_dut16 (
    .Clock(clk), .Reset(rst), .InValid(in_valid), .InReady(in_ready), .A(a), .B(b),
    .Op(op), .Shamt(shamt), .OutValid(out_valid), .OutReady(out_ready), .Result(result),
    .Zero(zero), .Overflow(ovf), .CarryOut(cout), .Busy(busy)
  );

  iter_alu #(.WIDTH(32)) u_dut32 (
    .Clock(clk), .Reset(rst), .InValid(in_valid32), .InReady(in_ready32), .A(a32), .B(b32),
    .Op(op32), .Shamt(shamt32), .OutValid(out_valid32), .OutReady(out_ready32),
    .Result(result32), .Zero(zero32), .Overflow(ovf32), .CarryOut(cout32), .Busy(busy32)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one op, return edges from accept until OutValid is seen (bounded)
  task automatic issue16(input logic [3:0] o, input logic [15:0] aa, input logic [15:0] bb,
                         input logic [3:0] sh, output int n);
    op = o; a = aa; b = bb; shamt = sh; in_valid = 1'b1;
    check("in_ready_before_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic retire16();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("retired16", out_valid, 0);
  endtask

  task automatic issue32(input logic [3:0] o, input logic [31:0] aa, input logic [31:0] bb,
                         input logic [4:0] sh, output int n);
    op32 = o; a32 = aa; b32 = bb; shamt32 = sh; in_valid32 = 1'b1;
    check("in_ready32_before_accept", in_ready32, 1);
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    n = 1;
    while (!out_valid32 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic retire32();
    out_ready32 = 1'b1;
    @(posedge clk); #1;
    out_ready32 = 1'b0;
    check("retired32", out_valid32, 0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 0; out_ready = 0; a = 0; b = 0; op = 0; shamt = 0;
    in_valid32 = 0; out_ready32 = 0; a32 = 0; b32 = 0; op32 = 0; shamt32 = 0;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 0);
    check("rst_ovf", ovf, 0);
    check("rst_cout", cout, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    issue16(C_ADD, 16'h7FFF, 16'h0001, 4'd0, lat);
    check("add_lat", lat, 1);
    check("add_res", result, 16'h8000);
    check("add_ovf", ovf, 1);
    check("add_cout", cout, 0);
    check("add_zero", zero, 0);
    check("done_in_ready", in_ready, 0);
    retire16();

    issue16(C_SUB, 16'd5, 16'd5, 4'd0, lat);
    check("sub_res", result, 0);
    check("sub_zero", zero, 1);
    check("sub_cout", cout, 1);
    check("sub_ovf", ovf, 0);
    retire16();

    issue16(C_SLT, 16'hFFFE, 16'h0001, 4'd0, lat);
    check("slt_res", result, 1);
    retire16();

    issue16(C_AND, 16'hF0F0, 16'hFF00, 4'd0, lat);
    check("and_res", result, 16'hF000);
    retire16();
    issue16(C_OR, 16'hF0F0, 16'hFF00, 4'd0, lat);
    check("or_res", result, 16'hFFF0);
    retire16();
    issue16(C_XOR, 16'hF0F0, 16'hFF00, 4'd0, lat);
    check("xor_res", result, 16'h0FF0);
    retire16();

    issue16(C_SRA, 16'h8000, 16'h0000, 4'd3, lat);
    check("sra3_lat", lat, SRA3_LAT);
    check("sra3_res", result, 16'hF000);
    retire16();

    issue16(C_SRA, 16'h8000, 16'h0000, 4'd0, lat);
    check("sra0_lat", lat, 1);
    check("sra0_res", result, 16'h8000);
    retire16();

    issue16(C_SLL, 16'h0003, 16'h0000, 4'd4, lat);
    check("sll4_lat", lat, SLL4_LAT);
    check("sll4_res", result, 16'h0030);
    retire16();

    issue16(C_BAD, 16'h0001, 16'h0001, 4'd0, lat);
    check("bad_lat", lat, 1);
    check("bad_res", result, 0);
    check("bad_ovf", ovf, 0);
    check("bad_cout", cout, 0);
    retire16();

    issue16(C_MUL, 16'hFFFF, 16'hFFFF, 4'd0, lat);
    check("mul_ff_res", result, 16'h0001);
    retire16();

    issue16(C_MUL, 16'h0123, 16'h0010, 4'd0, lat);
    check("mul_lat", lat, 17);
    check("mul_res", result, 16'h1230);
    // Hold the result while a second op is offered; it must be ignored
    op = C_ADD; a = 16'h0000; b = 16'h0000; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_res", result, 16'h1230);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    retire16();
    check("ignored_op_busy", busy, 0);

    // Reset in the middle of a multiply
    op = C_MUL; a = 16'h0123; b = 16'h0010; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("mid_mul_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    issue16(C_ADD, 16'd2, 16'd3, 4'd0, lat);
    check("post_rst_add", result, 5);
    retire16();

    // Back-to-back with OutReady tied high: one result every two cycles
    op = C_ADD; a = 16'd1; b = 16'd1; in_valid = 1'b1; out_ready = 1'b1;
    nres = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) nres++;
    end
    in_valid = 1'b0;
    check("b2b_count", nres, 5);
    check("b2b_res", result, 2);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("b2b_drained", busy, 0);

    issue32(C_SLL, 32'h1, 32'h0, 5'd31, lat);
    check("sll31_lat", lat, SLL31_LAT);
    check("sll31_res", result32, 32'h8000_0000);
    retire32();

    issue32(C_MUL, 32'h0001_0000, 32'h0001_0000, 5'd0, lat);
    check("mul32_lat", lat, 33);
    check("mul32_res", result32, 0);
    check("mul32_zero", zero32, 1);
    retire32();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
